// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer for the
// ARM-subset core. Owns PC and IR, evaluates the condition field, issues
// one-cycle datapath enables and runs req/ack memory handshakes with a
// wait-state timeout that parks the machine in FAULT.
module multicycle_ctrl #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                TIMEOUT  = 16,
    parameter int                CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    input  logic [1:0]        cls,
    input  logic [3:0]        opcode,
    input  logic              set_cond,
    input  logic              is_load,
    input  logic [3:0]        flags,
    output logic              alu_en,
    output logic              flags_we,
    output logic              rf_we,
    output logic              lr_we,
    output logic [ADDR_W-1:0] lr_val,
    output logic              dmem_req,
    output logic              dmem_we,
    input  logic              dmem_ack,
    output logic [CNT_W-1:0]  retired,
    output logic              fault,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_FAULT     = 3'd7
    } state_t;

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [31:0]         instr_q, instr_d;
    logic [CNT_W-1:0]    retired_q, retired_d;
    logic                fault_q, fault_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    // Holds imem_req once raised so a later drop of run cannot abort it.
    logic                busy_q, busy_d;

    logic signed [25:0]  br_off26;
    logic [ADDR_W-1:0]   br_off;
    logic                wait_hit;
    logic                cond_ok;

    assign br_off26  = {instr_q[23:0], 2'b00};
    assign br_off    = ADDR_W'(br_off26);
    assign wait_hit  = (wait_q == WAIT_W'(TIMEOUT - 1));
    assign imem_addr = pc_q;
    assign instr     = instr_q;
    assign retired   = retired_q;
    assign fault     = fault_q;
    assign state     = state_q;

    // ARM condition codes against NZCV; code 15 (NV) is treated as a fail.
    always_comb begin
        cond_ok = 1'b0;
        case (instr_q[31:28])
            4'd0:    cond_ok = flags[2];
            4'd1:    cond_ok = !flags[2];
            4'd2:    cond_ok = flags[1];
            4'd3:    cond_ok = !flags[1];
            4'd4:    cond_ok = flags[3];
            4'd5:    cond_ok = !flags[3];
            4'd6:    cond_ok = flags[0];
            4'd7:    cond_ok = !flags[0];
            4'd8:    cond_ok = flags[1] && !flags[2];
            4'd9:    cond_ok = !flags[1] || flags[2];
            4'd10:   cond_ok = (flags[3] == flags[0]);
            4'd11:   cond_ok = (flags[3] != flags[0]);
            4'd12:   cond_ok = !flags[2] && (flags[3] == flags[0]);
            4'd13:   cond_ok = flags[2] || (flags[3] != flags[0]);
            4'd14:   cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    // Next-state and Moore outputs; ack beats a timeout landing on the same edge.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        retired_d = retired_q;
        fault_d   = fault_q;
        wait_d    = '0;
        busy_d    = 1'b0;
        imem_req  = 1'b0;
        alu_en    = 1'b0;
        flags_we  = 1'b0;
        rf_we     = 1'b0;
        lr_we     = 1'b0;
        lr_val    = '0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        case (state_q)
            S_FETCH: begin
                // rst_n gating drops req the instant reset asserts
                imem_req = rst_n && (run || busy_q);
                if (imem_req) begin
                    if (imem_ack) begin
                        instr_d = imem_rdata;
                        pc_d    = pc_q + ADDR_W'(4);
                        state_d = S_DECODE;
                    end else if (wait_hit) begin
                        fault_d = 1'b1;
                        state_d = S_FAULT;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                        busy_d = 1'b1;
                    end
                end
            end
            S_DECODE: begin
                if (!cond_ok) begin
                    retired_d = retired_q + CNT_W'(1);
                    state_d   = S_FETCH;
                end else if (cls == 2'b11) begin
                    fault_d = 1'b1;
                    state_d = S_FAULT;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                alu_en = 1'b1;
                case (cls)
                    2'b00: state_d = S_WRITEBACK;
                    2'b01: state_d = S_MEMORY;
                    2'b10: begin
                        // pc already holds instr addr + 4
                        pc_d      = pc_q + ADDR_W'(4) + br_off;
                        lr_we     = instr_q[24];
                        lr_val    = instr_q[24] ? pc_q : '0;
                        retired_d = retired_q + CNT_W'(1);
                        state_d   = S_FETCH;
                    end
                    default: begin
                        fault_d = 1'b1;
                        state_d = S_FAULT;
                    end
                endcase
            end
            S_MEMORY: begin
                dmem_req = 1'b1;
                dmem_we  = !is_load;
                if (dmem_ack) begin
                    if (is_load) begin
                        state_d = S_WRITEBACK;
                    end else begin
                        retired_d = retired_q + CNT_W'(1);
                        state_d   = S_FETCH;
                    end
                end else if (wait_hit) begin
                    fault_d = 1'b1;
                    state_d = S_FAULT;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_WRITEBACK: begin
                // compare-class ops only update flags
                rf_we     = !((cls == 2'b00) && (opcode[3:2] == 2'b10));
                flags_we  = (cls == 2'b00) && set_cond;
                retired_d = retired_q + CNT_W'(1);
                state_d   = S_FETCH;
            end
            default: state_d = S_FAULT;
        endcase
    end

    // State register with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            retired_q <= '0;
            fault_q   <= 1'b0;
            wait_q    <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
            fault_q   <= fault_d;
            wait_q    <= wait_d;
            busy_q    <= busy_d;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: one linear sequence of instructions
// with hand-computed PC, retired count and per-cycle enable expectations.
module tb_multicycle_ctrl;

    logic        clk, rst_n, run;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata, instr, lr_val, retired;
    logic [1:0]  cls;
    logic [3:0]  opcode, flags;
    logic        set_cond, is_load;
    logic        alu_en, flags_we, rf_we, lr_we;
    logic        dmem_req, dmem_we, dmem_ack, fault;
    logic [2:0]  state;

    int checks = 0;
    int errors = 0;

    multicycle_ctrl #(.ADDR_W(32), .RESET_PC(32'h0), .TIMEOUT(16), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr(instr), .cls(cls), .opcode(opcode),
        .set_cond(set_cond), .is_load(is_load), .flags(flags),
        .alu_en(alu_en), .flags_we(flags_we), .rf_we(rf_we), .lr_we(lr_we),
        .lr_val(lr_val), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_ack(dmem_ack), .retired(retired), .fault(fault), .state(state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Issue one zero-wait fetch; returns with the DUT in DECODE.
    task automatic fetch(input logic [31:0] word);
        run = 1'b1;
        imem_ack = 1'b1;
        imem_rdata = word;
        step();
        imem_ack = 1'b0;
        run = 1'b0;
        chk("decode_state", {29'd0, state}, 32'd1);
        chk("ir", instr, word);
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        cls = '0; opcode = '0; set_cond = 1'b0; is_load = 1'b0; flags = '0;
        dmem_ack = 1'b0;

        // reset values
        step(); step();
        chk("rst_state", {29'd0, state}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_retired", retired, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_en", {24'd0, alu_en, flags_we, rf_we, lr_we, dmem_req, dmem_we, imem_req, 1'b0}, 32'd0);
        chk("rst_lr", lr_val, 32'h0);
        run = 1'b1; #1;
        chk("rst_req_run", {31'd0, imem_req}, 32'd0);
        run = 1'b0;
        step(); rst_n = 1'b1;

        // ADD r0,r0,#4: 4 cycles
        step();
        cls = 2'b00; opcode = 4'd4;
        run = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hE280_0004; #1;
        chk("add_req", {31'd0, imem_req}, 32'd1);
        chk("add_addr", imem_addr, 32'h0);
        step(); imem_ack = 1'b0; run = 1'b0;
        chk("add_dec", {29'd0, state}, 32'd1);
        chk("add_ir", instr, 32'hE280_0004);
        step();
        chk("add_ex", {29'd0, state}, 32'd2);
        chk("add_alu", {31'd0, alu_en}, 32'd1);
        step();
        chk("add_wb", {29'd0, state}, 32'd4);
        chk("add_rfwe", {30'd0, rf_we, alu_en}, 32'b10);
        chk("add_fwe", {31'd0, flags_we}, 32'd0);
        step();
        chk("add_fetch", {29'd0, state}, 32'd0);
        chk("add_ret", retired, 32'd1);
        chk("add_pc", imem_addr, 32'h4);
        chk("add_idle", {31'd0, imem_req}, 32'd0);

        // spurious ack while idle
        imem_ack = 1'b1; step(); imem_ack = 1'b0;
        chk("spur_state", {29'd0, state}, 32'd0);
        chk("spur_ir", instr, 32'hE280_0004);

        // EQ fails with Z=0: 2 cycles
        flags = 4'b0000;
        fetch(32'h0123_4567);
        chk("eq_noalu", {31'd0, alu_en}, 32'd0);
        step();
        chk("eq_state", {29'd0, state}, 32'd0);
        chk("eq_ret", retired, 32'd2);
        chk("eq_pc", imem_addr, 32'h8);

        // NV always skips, even with all flags set
        flags = 4'hF;
        fetch(32'hF000_0000);
        step();
        chk("nv_state", {29'd0, state}, 32'd0);
        chk("nv_ret", retired, 32'd3);
        chk("nv_pc", imem_addr, 32'hC);
        flags = 4'h0;

        // CMP with S: flags_we only
        opcode = 4'd10; set_cond = 1'b1;
        fetch(32'hE350_0000);
        step();
        step();
        chk("cmp_wb", {29'd0, state}, 32'd4);
        chk("cmp_we", {30'd0, flags_we, rf_we}, 32'b10);
        step();
        chk("cmp_ret", retired, 32'd4);
        chk("cmp_pc", imem_addr, 32'h10);
        set_cond = 1'b0; opcode = 4'd0;

        // BL +2 at 0x10: 3 cycles, target 0x20, LR 0x14
        cls = 2'b10;
        fetch(32'hEB00_0002);
        step();
        chk("bl_ex", {29'd0, state}, 32'd2);
        chk("bl_lrwe", {30'd0, lr_we, alu_en}, 32'b11);
        chk("bl_lrval", lr_val, 32'h14);
        step();
        chk("bl_state", {29'd0, state}, 32'd0);
        chk("bl_pc", imem_addr, 32'h20);
        chk("bl_ret", retired, 32'd5);
        chk("bl_lr_off", {31'd0, lr_we}, 32'd0);

        // LDR with dmem ack after 3 wait cycles: 8 cycles
        cls = 2'b01; is_load = 1'b1;
        fetch(32'hE591_0000);
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 3) begin dmem_ack = 1'b1; #1; end
            chk("ld_mem", {29'd0, state}, 32'd3);
            chk("ld_req", {30'd0, dmem_req, dmem_we}, 32'b10);
        end
        step(); dmem_ack = 1'b0;
        chk("ld_wb", {29'd0, state}, 32'd4);
        chk("ld_rfwe", {30'd0, rf_we, dmem_req}, 32'b10);
        step();
        chk("ld_ret", retired, 32'd6);
        chk("ld_pc", imem_addr, 32'h24);

        // STR zero-wait: 4 cycles, no rf_we
        is_load = 1'b0; dmem_ack = 1'b1;
        fetch(32'hE581_0000);
        step();
        chk("st_ex_rf", {31'd0, rf_we}, 32'd0);
        step();
        chk("st_mem", {29'd0, state}, 32'd3);
        chk("st_we", {29'd0, dmem_req, dmem_we, rf_we}, 32'b110);
        step(); dmem_ack = 1'b0;
        chk("st_state", {29'd0, state}, 32'd0);
        chk("st_ret", retired, 32'd7);
        chk("st_pc", imem_addr, 32'h28);

        // undefined class traps after DECODE and stays there
        cls = 2'b11;
        fetch(32'hE7F0_00F0);
        step();
        chk("und_state", {29'd0, state}, 32'd7);
        chk("und_fault", {30'd0, fault, alu_en}, 32'b10);
        run = 1'b1; imem_ack = 1'b1;
        step();
        chk("und_hold", {29'd0, state}, 32'd7);
        chk("und_noreq", {31'd0, imem_req}, 32'd0);
        run = 1'b0; imem_ack = 1'b0;

        // reset from FAULT
        rst_n = 1'b0; #1;
        chk("rst2_state", {29'd0, state}, 32'd0);
        chk("rst2_fault", {31'd0, fault}, 32'd0);
        chk("rst2_ret", retired, 32'd0);
        chk("rst2_pc", imem_addr, 32'h0);
        step(); rst_n = 1'b1;

        // ack on the edge the timeout would hit: ack wins
        cls = 2'b00; opcode = 4'd4;
        step();
        run = 1'b1; imem_ack = 1'b0;
        repeat (15) step();
        chk("aw_wait", {29'd0, state}, 32'd0);
        imem_ack = 1'b1; imem_rdata = 32'hE280_0004; #1;
        step(); imem_ack = 1'b0; run = 1'b0;
        chk("aw_state", {29'd0, state}, 32'd1);
        chk("aw_fault", {31'd0, fault}, 32'd0);
        step(); step(); step();
        chk("aw_ret", retired, 32'd1);

        // timeout: req held 16 cycles despite run dropping
        run = 1'b1; #1;
        chk("to_req0", {31'd0, imem_req}, 32'd1);
        for (int i = 1; i <= 15; i++) begin
            step();
            if (i == 1) begin run = 1'b0; #1; end
            chk("to_req", {28'd0, state, imem_req}, 32'b0001);
        end
        step();
        chk("to_state", {29'd0, state}, 32'd7);
        chk("to_fault", {30'd0, fault, imem_req}, 32'b10);
        step();
        chk("to_hold", {29'd0, state}, 32'd7);

        // reset mid-wait drops req at once
        rst_n = 1'b0; step(); rst_n = 1'b1;
        step();
        run = 1'b1;
        repeat (5) step();
        chk("mw_req", {31'd0, imem_req}, 32'd1);
        #1 rst_n = 1'b0; #1;
        chk("mw_drop", {31'd0, imem_req}, 32'd0);
        chk("mw_vals", {retired[7:0], 15'd0, fault, 5'd0, state, imem_addr[7:0]}, 32'd0);
        step(); rst_n = 1'b1; run = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Parametrised multi-cycle sequencer for the ARM-subset core. It replaces the free-running, testbench-driven datapath hookup with a clocked FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK state machine. It owns the PC and instruction register, evaluates the ARM condition field, and issues the enables consumed by the existing decoder, barrel shifter, ALU and register file. Memory is reached through req/ack handshakes with a wait-state timeout.

## Interface
- `ADDR_W`, 32: PC and instruction-memory address width (≥ 26).
- `RESET_PC`, 0: PC value loaded on reset.
- `TIMEOUT`, 16: maximum wait cycles for any memory ack before fault (≥ 1).
- `CNT_W`, 32: retired-instruction counter width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `run` in 1: when low, the FSM idles in FETCH without requesting.
- `imem_req` out 1, `imem_addr` out ADDR_W, `imem_ack` in 1, `imem_rdata` in 32: instruction fetch handshake.
- `instr` out 32: latched instruction register, feeding the decoder.
- `cls` in 2: decoder class (00 data-proc, 01 load/store, 10 branch, 11 undefined).
- `opcode` in 4, `set_cond` in 1, `is_load` in 1: decoder fields.
- `flags` in 4: current NZCV.
- `alu_en`, `flags_we`, `rf_we`, `lr_we` out 1 each: datapath enables.
- `lr_val` out ADDR_W: return address for branch-with-link.
- `dmem_req` out 1, `dmem_we` out 1, `dmem_ack` in 1: data memory handshake.
- `retired` out CNT_W: count of completed instructions.
- `fault` out 1: sticky error flag.
- `state` out 3: FSM state, for debug.

## Operation
- State encodings: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, FAULT=7.
- FETCH
  - With `run`=1, `imem_req`=1 and `imem_addr`=pc.
  - On a sampled `imem_ack`: `instr`<=`imem_rdata`, pc<=pc+4, go to DECODE.
- DECODE
  - Evaluate cond=`instr[31:28]` against `flags` using standard ARM codes 0–14. Code 15 counts as a fail.
  - On fail: `retired`+1, go to FETCH.
  - If `cls`=11: go to FAULT.
  - Otherwise go to EXECUTE.
- EXECUTE (`alu_en`=1 for exactly this cycle)
  - Data-proc: go to WRITEBACK.
  - Load/store: go to MEMORY.
  - Branch:
    - pc<=pc+4+(sext(`instr[23:0]`)<<2), i.e. instruction address+8+offset, truncated to ADDR_W.
    - If `instr[24]`: `lr_we`=1 with `lr_val`=pc (instruction address+4).
    - `retired`+1, go to FETCH.
- MEMORY
  - `dmem_req`=1 and `dmem_we`=!`is_load` until ack.
  - On ack, a store: `retired`+1, go to FETCH. A load: go to WRITEBACK.
- WRITEBACK
  - `rf_we`=1, except data-proc with `opcode` 8–11 (TST/TEQ/CMP/CMN).
  - `flags_we`=`set_cond`, data-proc only.
  - `retired`+1, go to FETCH.
- Timeout
  - A wait counter runs while req is high without ack and clears on ack or state change.
  - When it reaches TIMEOUT: drop req, set `fault`, go to FAULT.
- FAULT is absorbing until reset. All enables and reqs are 0 there.
- `retired` wraps modulo 2^CNT_W.

## Timing
- Reset (async assert, sync release): state=FETCH, pc=`imem_addr`=RESET_PC, `instr`=0, `retired`=0, `fault`=0, all enables/reqs/`dmem_we`/`lr_val`=0.
- Ack may be combinational with req; it is sampled on the rising edge where req=1.
- Zero-wait cycle counts:
  - Data-proc: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
  - Condition-failed: 2 cycles.
- Each wait cycle adds 1.
- `run` is sampled only in FETCH, before req is raised. Once req is high it stays high until ack or timeout, regardless of `run`.
- Enables are Moore outputs of the state and last exactly one cycle per instruction.
- `rst_n` low mid-transaction drops req the same instant. No partial writeback is issued.
- An ack arriving on the same edge as the timeout hit: the ack wins.
- Spurious acks (req=0) are ignored.

## Test plan
- Reset release, `run`=1, zero-wait memory returning 0xE2800004 (ADD r0,r0,#4, cls=00, opcode=4): req at 0x0; `alu_en` in cycle 3; `rf_we` in cycle 4; `retired`=1; next `imem_addr`=0x4.
- Branch-with-link 0xEB000002 fetched at 0x10: `lr_we`=1 with `lr_val`=0x14; next fetch at 0x20; 3 cycles.
- Condition fail, 0x0xxxxxxx (EQ) with `flags`=0000: 2 cycles, no `alu_en`, `retired`+1. Also cond=0xF always skips.
- Load with `dmem_ack` delayed 3 cycles: `dmem_req` high 4 cycles with `dmem_we`=0, then `rf_we`; 8 cycles total. Store: `dmem_we`=1, no `rf_we`.
- CMP with `set_cond`=1 (opcode 10): `flags_we`=1, `rf_we`=0. Undefined class: FAULT after DECODE.
- `imem_ack` withheld, TIMEOUT=16: `fault`=1 after 16 wait cycles; req drops; FAULT held. `rst_n` pulse mid-wait restores all reset values.
